// File: rtl/mask_prng.sv
// -----------------------------------------------------------------------------
// mask_prng
//
// Generates fresh-mask randomness for a 3-share masked S-box. A 31-bit
// Fibonacci LFSR (x^31 + x^28 + 1) is advanced 24 steps per cycle, and each
// 24-bit advance is split into four 6-bit mask words {rs, r3, r2, r1}.
// After seeding (or an en start from IDLE) the generator discards WARMUP
// advances, then presents one registered mask word at a time through a
// valid/ready handshake.
//
// Parameters
//   SEED_DEFAULT  LFSR state loaded at reset (must be nonzero)
//   WARMUP        discarded advances after seeding, 0..15
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          start request from IDLE using the current LFSR state
//   seed_valid  seed offer
//   seed_data   31-bit seed value (zero is replaced by 31'h1)
//   seed_ready  seed acceptance (low only while warming up)
//   rnd_valid   mask word valid
//   rnd_ready   consumer accepts the current mask word
//   r1,r2,r3,rs registered 6-bit mask words
//   seed_zero   one-cycle pulse after a zero seed was substituted
// -----------------------------------------------------------------------------
module mask_prng #(
    parameter logic [30:0] SEED_DEFAULT = 31'h5A5A1234,
    parameter int unsigned WARMUP       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        seed_valid,
    input  logic [30:0] seed_data,
    output logic        seed_ready,
    output logic        rnd_valid,
    input  logic        rnd_ready,
    output logic [5:0]  r1,
    output logic [5:0]  r2,
    output logic [5:0]  r3,
    output logic [5:0]  rs,
    output logic        seed_zero
);

    localparam logic [3:0] WARM_LAST = 4'(WARMUP);

    // A zero reset seed would lock the LFSR; fall back to 1 in that case.
    localparam logic [30:0] SEED_RST = (SEED_DEFAULT == 31'd0) ? 31'd1 : SEED_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    typedef struct packed {
        logic [30:0] s;     // LFSR state after 24 steps
        logic [23:0] bits;  // generated bits, first bit at [0]
    } adv_t;

    state_t      state_q, state_d;
    logic [30:0] lfsr_q,  lfsr_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [23:0] word_q,  word_d;
    logic        seed_zero_q, seed_zero_d;

    adv_t        adv;
    logic        seed_fire;
    logic        rnd_fire;
    logic        seed_is_zero;
    logic [30:0] seed_load;

    // Unrolled 24-step advance of the LFSR. Bit i of the result is the
    // feedback bit produced by step i.
    function automatic adv_t advance(input logic [30:0] s_in);
        adv_t        res;
        logic [30:0] s;
        logic        nb;
        s        = s_in;
        res.bits = '0;
        for (int i = 0; i < 24; i++) begin
            nb          = s[30] ^ s[27];
            res.bits[i] = nb;
            s           = {s[29:0], nb};
        end
        res.s = s;
        return res;
    endfunction

    assign seed_ready = (state_q != ST_WARMUP);
    assign rnd_valid  = (state_q == ST_RUN);

    assign seed_fire    = seed_valid & seed_ready;
    assign rnd_fire     = rnd_valid & rnd_ready;
    assign seed_is_zero = (seed_data == 31'd0);
    assign seed_load    = seed_is_zero ? 31'd1 : seed_data;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        seed_zero_d = 1'b0;
        adv         = advance(lfsr_q);

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    cnt_d   = 4'd0;
                    state_d = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                lfsr_d = adv.s;
                if (cnt_q == WARM_LAST) begin
                    // Warmup done: this advance becomes the first mask word.
                    word_d  = adv.bits;
                    cnt_d   = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RUN: begin
                if (rnd_fire) begin
                    word_d = adv.bits;
                    lfsr_d = adv.s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A seed transfer (possible only in IDLE or RUN) overrides everything
        // above: it beats en, and beats a simultaneous word consumption without
        // loading a new word.
        if (seed_fire) begin
            lfsr_d      = seed_load;
            word_d      = word_q;
            cnt_d       = 4'd0;
            seed_zero_d = seed_is_zero;
            state_d     = ST_WARMUP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= SEED_RST;
            cnt_q       <= 4'd0;
            word_q      <= '0;
            seed_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            seed_zero_q <= seed_zero_d;
        end
    end

    assign r1        = word_q[5:0];
    assign r2        = word_q[11:6];
    assign r3        = word_q[17:12];
    assign rs        = word_q[23:18];
    assign seed_zero = seed_zero_q;

endmodule

// File: tb/tb_mask_prng.sv
// -----------------------------------------------------------------------------
// tb_mask_prng
//
// Two instances share all inputs: dut_a with WARMUP=0 (mask word values,
// handshake corner cases) and dut_b with WARMUP=4 (warmup latency).
// Expected mask words are derived by hand from the LFSR recurrence
// a[n] = a[n-31] ^ a[n-28].
// -----------------------------------------------------------------------------
module tb_mask_prng;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        seed_valid;
    logic [30:0] seed_data;
    logic        rnd_ready;

    logic        a_seed_ready, a_rnd_valid, a_seed_zero;
    logic [5:0]  a_r1, a_r2, a_r3, a_rs;
    logic        b_seed_ready, b_rnd_valid, b_seed_zero;
    logic [5:0]  b_r1, b_r2, b_r3, b_rs;

    int n_vec;
    int n_err;

    mask_prng #(.SEED_DEFAULT(31'h5A5A1234), .WARMUP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(a_seed_ready),
        .rnd_valid(a_rnd_valid), .rnd_ready(rnd_ready),
        .r1(a_r1), .r2(a_r2), .r3(a_r3), .rs(a_rs), .seed_zero(a_seed_zero)
    );

    mask_prng #(.SEED_DEFAULT(31'h5A5A1234), .WARMUP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(b_seed_ready),
        .rnd_valid(b_rnd_valid), .rnd_ready(rnd_ready),
        .r1(b_r1), .r2(b_r2), .r3(b_r3), .rs(b_rs), .seed_zero(b_seed_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [30:0] sd;
        logic        en;
        logic        rr;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[13];

    // {rnd_valid, seed_ready, seed_zero, r1, r2, r3, rs}
    function automatic logic [26:0] pk(input logic v, input logic rdy, input logic z,
                                       input logic [5:0] w1, input logic [5:0] w2,
                                       input logic [5:0] w3, input logic [5:0] w4);
        return {v, rdy, z, w1, w2, w3, w4};
    endfunction

    function automatic logic [26:0] act_a();
        return pk(a_rnd_valid, a_seed_ready, a_seed_zero, a_r1, a_r2, a_r3, a_rs);
    endfunction

    function automatic logic [26:0] act_b();
        return pk(b_rnd_valid, b_seed_ready, b_seed_zero, b_r1, b_r2, b_r3, b_rs);
    endfunction

    task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        seed_valid = 1'b0;
        seed_data  = '0;
        rnd_ready  = 1'b0;

        // Vector table for dut_a (WARMUP=0): inputs applied before an edge,
        // outputs expected just after it.
        vecs[0]  = '{1'b1, 31'd0, 1'b0, 1'b1, pk(0, 0, 1, 6'h00, 6'h00, 6'h00, 6'h00)}; // zero seed
        vecs[1]  = '{1'b0, 31'd0, 1'b0, 1'b1, pk(1, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00)}; // word1
        vecs[2]  = '{1'b0, 31'd0, 1'b0, 1'b1, pk(1, 1, 0, 6'h08, 6'h01, 6'h00, 6'h00)}; // word2
        vecs[3]  = '{1'b0, 31'd0, 1'b0, 1'b0, pk(1, 1, 0, 6'h08, 6'h01, 6'h00, 6'h00)}; // hold
        vecs[4]  = '{1'b0, 31'd0, 1'b0, 1'b1, pk(1, 1, 0, 6'h00, 6'h02, 6'h02, 6'h00)}; // word3
        vecs[5]  = '{1'b0, 31'd0, 1'b0, 1'b0, pk(1, 1, 0, 6'h00, 6'h02, 6'h02, 6'h00)}; // hold
        vecs[6]  = '{1'b1, 31'd1, 1'b0, 1'b1, pk(0, 0, 0, 6'h00, 6'h02, 6'h02, 6'h00)}; // seed+rnd
        vecs[7]  = '{1'b0, 31'd0, 1'b0, 1'b0, pk(1, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00)}; // word1
        vecs[8]  = '{1'b0, 31'd0, 1'b0, 1'b0, pk(1, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00)}; // hold
        vecs[9]  = '{1'b0, 31'd0, 1'b0, 1'b1, pk(1, 1, 0, 6'h08, 6'h01, 6'h00, 6'h00)}; // word2
        vecs[10] = '{1'b0, 31'd0, 1'b0, 1'b1, pk(1, 1, 0, 6'h00, 6'h02, 6'h02, 6'h00)}; // word3
        vecs[11] = '{1'b0, 31'd0, 1'b0, 1'b1, pk(1, 1, 0, 6'h00, 6'h20, 6'h24, 6'h04)}; // word4
        vecs[12] = '{1'b0, 31'd0, 1'b1, 1'b0, pk(1, 1, 0, 6'h00, 6'h20, 6'h24, 6'h04)}; // en in RUN

        // Reset state, before any clock edge.
        #1;
        chk("reset_a", act_a(), pk(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00));
        chk("reset_b", act_b(), pk(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00));
        step();
        rst_n = 1'b1;
        step();
        chk("idle_a", act_a(), pk(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00));
        step();
        chk("idle_a2", act_a(), pk(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00));

        for (int i = 0; i < 13; i++) begin
            seed_valid = vecs[i].sv;
            seed_data  = vecs[i].sd;
            en         = vecs[i].en;
            rnd_ready  = vecs[i].rr;
            step();
            chk($sformatf("vec%0d", i), act_a(), vecs[i].exp);
        end
        seed_valid = 1'b0;
        seed_data  = '0;
        en         = 1'b0;
        rnd_ready  = 1'b0;

        // Long stall in RUN, then a single consume.
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("stall%0d", i), act_a(), pk(1, 1, 0, 6'h00, 6'h20, 6'h24, 6'h04));
        end
        rnd_ready = 1'b1;
        step();
        rnd_ready = 1'b0;
        chk("word5", act_a(), pk(1, 1, 0, 6'h00, 6'h00, 6'h08, 6'h00));
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("word5_hold%0d", i), act_a(), pk(1, 1, 0, 6'h00, 6'h00, 6'h08, 6'h00));
        end

        // WARMUP=4 latency on dut_b: seed at edge T, valid from T+5.
        chk("b_ready_pre", pk(b_rnd_valid, b_seed_ready, 0, 0, 0, 0, 0), pk(1, 1, 0, 0, 0, 0, 0));
        seed_valid = 1'b1;
        seed_data  = 31'd5;
        for (int k = 0; k < 6; k++) begin
            step();
            seed_valid = 1'b0;
            seed_data  = '0;
            chk($sformatf("b_lat_T+%0d", k), pk(b_rnd_valid, b_seed_ready, 0, 0, 0, 0, 0),
                (k == 5) ? pk(1, 1, 0, 0, 0, 0, 0) : pk(0, 0, 0, 0, 0, 0, 0));
        end

        // dut_a holds word1 of seed 5 (zero); consume once for a nonzero word.
        rnd_ready = 1'b1;
        step();
        rnd_ready = 1'b0;
        chk("seed5_word2", act_a(), pk(1, 1, 0, 6'h1A, 6'h01, 6'h00, 6'h00));

        // Reset mid-RUN takes effect without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_a", act_a(), pk(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00));
        chk("rst_mid_b", act_b(), pk(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00));
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst%0d", i), act_a(), pk(0, 1, 0, 6'h00, 6'h00, 6'h00, 6'h00));
        end
        en = 1'b1;
        step();
        en = 1'b0;
        chk("en_warm", pk(a_rnd_valid, a_seed_ready, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0, 0));
        step();
        chk("en_run", pk(a_rnd_valid, a_seed_ready, 0, 0, 0, 0, 0), pk(1, 1, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mask_prng.md
MASK_PRNG -- requirements
Module: mask_prng

Interface
REQ-001 Parameter SEED_DEFAULT, 31'h5A5A1234, nonzero LFSR state loaded at reset.
REQ-002 Parameter WARMUP, 4, number of discarded 24-bit advances after seeding, legal range 0..15.
REQ-003 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port en  input  1  start request from IDLE using the current LFSR state.
REQ-006 Port seed_valid  input  1  seed offer.
REQ-007 Port seed_data  input  31  seed value.
REQ-008 Port seed_ready  output  1  seed acceptance; transfer when seed_valid and seed_ready are both high.
REQ-009 Port rnd_valid  output  1  mask word valid.
REQ-010 Port rnd_ready  input  1  consumer takes the word; transfer when rnd_valid and rnd_ready are both high.
REQ-011 Ports r1, r2, r3, rs  output  6 each  fresh-mask word for the 3-share masked S-box component functions.
REQ-012 Port seed_zero  output  1  one-cycle pulse when a zero seed was substituted.

Function
REQ-013 LFSR: 31-bit s with x^31+x^28+1; one step sets new = s[30]^s[27] and s <= {s[29:0], new}.
REQ-014 Advance: 24 consecutive steps in one cycle, fully unrolled; the 24 new bits in generation order SHALL form {rs,r3,r2,r1}, first bit at r1[0], last at rs[5].
REQ-015 States: IDLE, WARMUP, RUN, encoded in one FSM register.
REQ-016 IDLE: rnd_valid=0, seed_ready=1; en=1 -> WARMUP with the LFSR unchanged; seed transfer -> WARMUP.
REQ-017 Seed transfer: s <= seed_data, or 31'h1 when seed_data==0; when substituted, seed_zero=1 on the following cycle only; warmup counter <= 0.
REQ-018 WARMUP: seed_ready=0, rnd_valid=0, one advance per cycle discarded; after WARMUP advances, the next edge loads the first word into r1/r2/r3/rs, advances s, and enters RUN.
REQ-019 Latency: a seed transfer at edge T SHALL give rnd_valid=1 from edge T+WARMUP+1.
REQ-020 RUN: rnd_valid=1, seed_ready=1; on an rnd transfer the output register loads the next advance, the same edge.
REQ-021 RUN without rnd_ready: r1/r2/r3/rs and s SHALL hold stable.
REQ-022 Seed transfer in RUN: the current word is discarded; rnd_valid=0 from the next edge; new seed handled as REQ-017 -> WARMUP.
REQ-023 Seed transfer and rnd transfer in the same cycle: the seed SHALL win; the word counts as consumed, no new word loads, and the next state is WARMUP.
REQ-024 en SHALL be ignored outside IDLE; RUN has no exit except a seed transfer or reset.
REQ-025 No all-zero LFSR state SHALL ever be reachable.
REQ-026 Mask outputs SHALL come only from registers, never combinationally from the LFSR.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, s=SEED_DEFAULT, warmup counter 0, r1=r2=r3=rs=0, rnd_valid=0, seed_zero=0, seed_ready=1.
REQ-028 Reset mid-WARMUP or mid-RUN SHALL abandon all progress; after release the block waits in IDLE.
REQ-029 Release of rst_n SHALL require a clock edge before any state change.

Verification
REQ-030 WARMUP=0; seed 31'h00000001 transferred with rnd_ready=1 -> first word r1=r2=r3=rs=0; second word r1=6'h08, r2=6'h01, r3=0, rs=0.
REQ-031 seed_data=0 transferred -> seed_zero pulses for exactly one cycle; output words are identical to the seed 31'h1 case.
REQ-032 WARMUP=4; seed at edge T -> rnd_valid=0 through T+4, 1 at T+5; seed_ready=0 throughout WARMUP.
REQ-033 RUN with rnd_ready=0 for 10 cycles -> outputs unchanged; then one rnd_ready pulse -> exactly one new word.
REQ-034 Seed transfer and rnd transfer in the same cycle -> rnd_valid=0 next cycle, WARMUP entered, no extra word emitted.
REQ-035 rst_n asserted mid-RUN -> all outputs zero with no clock edge; after release rnd_valid stays 0 until en or a seed.
